// File: rtl/core_cycle_seq.sv
// Clocked duplex core-memory cycle sequencer: destructive read, sense/vote, restore/write.
// Every copy stores each word as {p1,syl1,p0,syl0}, with odd parity per syllable.
module core_cycle_seq #(
  parameter int unsigned SYL_W     = 14,
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned NCH       = 2,
  parameter int unsigned RD_CYC    = 4,
  parameter int unsigned WR_CYC    = 4,
  parameter string       INIT_FILE = ""
) (
  input  logic                MmCLKV,
  input  logic                MmRSTVN,
  input  logic                MmREQV,
  input  logic                MmWRV,
  input  logic [1:0]          MmSYLV,
  input  logic [ADDR_W-1:0]   MmADDRV,
  input  logic [2*SYL_W-1:0]  MmWDV,
  output logic                MmACKV,
  output logic                MmBUSYV,
  output logic [2*SYL_W-1:0]  MmRDV,
  output logic                MmRVALV,
  output logic [1:0]          MmPERRV,
  output logic                MmDERRV,
  output logic                EDmX,
  output logic                EDmY
);
  localparam int unsigned DEPTH   = 1 << ADDR_W;
  localparam int unsigned FLD_W   = SYL_W + 1;
  localparam int unsigned WORD_W  = 2 * FLD_W;
  localparam int unsigned MAX_CYC = (RD_CYC > WR_CYC) ? RD_CYC : WR_CYC;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  typedef enum logic [1:0] {IDLE, READ, SENSE, WRITE} state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [ADDR_W-1:0]   cap_addr;
  logic                cap_wr;
  logic [1:0]          cap_syl;
  logic [2*SYL_W-1:0]  cap_wd;
  logic                drive;
  logic                pend;
  logic [2*SYL_W-1:0]  res_rd;
  logic [1:0]          res_perr;
  logic                res_derr;
  logic [WORD_W-1:0]   restore;

  logic                rd_last;
  logic                wr_last;
  logic [WORD_W-1:0]   word0;
  logic [WORD_W-1:0]   word1;
  logic [2*SYL_W-1:0]  vote_rd;
  logic [1:0]          vote_perr;
  logic                vote_derr;
  logic [WORD_W-1:0]   vote_restore;

  assign rd_last = (state == READ)  && (cnt == '0);
  assign wr_last = (state == WRITE) && (cnt == '0);
  assign EDmX    = drive;
  assign EDmY    = drive;

  // One array per copy; only the sequencer touches them, reset leaves contents alone.
  for (genvar g = 0; g < NCH; g++) begin : g_copy
    logic [WORD_W-1:0] mem [DEPTH];
    logic [WORD_W-1:0] sense;

    initial begin
      mem = '{default: '0};
    end

    always_ff @(posedge MmCLKV) begin
      if (rd_last) begin
        sense         <= mem[cap_addr];
        mem[cap_addr] <= '0;
      end else if (wr_last) begin
        mem[cap_addr] <= restore;
      end
    end
  end

  // With a single copy both views alias copy 0, so disagreement can never be flagged.
  assign word0     = g_copy[0].sense;
  assign word1     = g_copy[NCH-1].sense;
  assign vote_derr = (word0 != word1);

  always_comb begin
    logic [FLD_W-1:0] f0;
    logic [FLD_W-1:0] f1;
    logic [FLD_W-1:0] pick;
    logic [SYL_W-1:0] nd;
    logic             ok0;
    logic             ok1;
    vote_rd      = '0;
    vote_perr    = '0;
    vote_restore = '0;
    f0   = '0;
    f1   = '0;
    pick = '0;
    nd   = '0;
    ok0  = 1'b0;
    ok1  = 1'b0;
    for (int unsigned s = 0; s < 2; s++) begin
      f0   = word0[s*FLD_W +: FLD_W];
      f1   = word1[s*FLD_W +: FLD_W];
      ok0  = ^f0;
      ok1  = ^f1;
      pick = (ok0 || !ok1) ? f0 : f1;
      nd   = cap_wd[s*SYL_W +: SYL_W];
      // Bad parity on an unwritten syllable is written back as found.
      vote_restore[s*FLD_W +: FLD_W] = (cap_wr && cap_syl[s]) ? {~^nd, nd} : pick;
      if (cap_syl[s]) begin
        vote_rd[s*SYL_W +: SYL_W] = pick[SYL_W-1:0];
        vote_perr[s]              = !ok0 && !ok1;
      end
    end
  end

  always_ff @(posedge MmCLKV or negedge MmRSTVN) begin
    if (!MmRSTVN) begin
      state    <= IDLE;
      cnt      <= '0;
      cap_addr <= '0;
      cap_wr   <= 1'b0;
      cap_syl  <= '0;
      cap_wd   <= '0;
      drive    <= 1'b0;
      pend     <= 1'b0;
      res_rd   <= '0;
      res_perr <= '0;
      res_derr <= 1'b0;
      restore  <= '0;
      MmACKV   <= 1'b0;
      MmBUSYV  <= 1'b0;
      MmRDV    <= '0;
      MmRVALV  <= 1'b0;
      MmPERRV  <= '0;
      MmDERRV  <= 1'b0;
    end else begin
      MmACKV  <= 1'b0;
      MmRVALV <= 1'b0;
      unique case (state)
        IDLE: begin
          if (MmREQV) begin
            MmACKV   <= 1'b1;
            MmBUSYV  <= 1'b1;
            drive    <= 1'b1;
            cap_addr <= MmADDRV;
            cap_wr   <= MmWRV;
            cap_syl  <= (MmSYLV == 2'b00) ? 2'b11 : MmSYLV;
            cap_wd   <= MmWDV;
            cnt      <= CNT_W'(RD_CYC - 1);
            state    <= READ;
          end
        end
        READ: begin
          if (cnt == '0) begin
            drive <= 1'b0;
            state <= SENSE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        SENSE: begin
          res_rd   <= vote_rd;
          res_perr <= vote_perr;
          res_derr <= vote_derr;
          restore  <= vote_restore;
          pend     <= !cap_wr;
          drive    <= 1'b1;
          cnt      <= CNT_W'(WR_CYC - 1);
          state    <= WRITE;
        end
        WRITE: begin
          // Read results go out on the first WRITE clock so latency is RD_CYC+2.
          if (pend) begin
            MmRDV   <= res_rd;
            MmPERRV <= res_perr;
            MmDERRV <= res_derr;
            MmRVALV <= 1'b1;
            pend    <= 1'b0;
          end
          if (cnt == '0) begin
            drive   <= 1'b0;
            MmBUSYV <= 1'b0;
            state   <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_core_cycle_seq.sv
// Bench for core_cycle_seq: directed cycles, expected reads queued per instance and checked on RVALV.
// Instance a uses default parameters; instance b is single-copy with one-clock phases.
module tb_core_cycle_seq;
  localparam int unsigned SW = 14;
  localparam int unsigned AW = 12;

  typedef struct packed {
    logic [2*SW-1:0] rd;
    logic [1:0]      perr;
    logic            derr;
    logic [31:0]     cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic            req_a;
  logic            req_b;
  logic            wr;
  logic [1:0]      syl;
  logic [AW-1:0]   addr;
  logic [2*SW-1:0] wd;

  logic            ack_a, busy_a, rval_a, derr_a, ex_a, ey_a;
  logic [2*SW-1:0] rd_a;
  logic [1:0]      perr_a;
  logic            ack_b, busy_b, rval_b, derr_b, ex_b, ey_b;
  logic [2*SW-1:0] rd_b;
  logic [1:0]      perr_b;

  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;
  exp_t q_a[$];
  exp_t q_b[$];

  always @(posedge clk) cyc <= cyc + 1;

  core_cycle_seq #(.SYL_W(SW), .ADDR_W(AW), .NCH(2), .RD_CYC(4), .WR_CYC(4)) dut_a (
    .MmCLKV(clk), .MmRSTVN(rst_n), .MmREQV(req_a), .MmWRV(wr), .MmSYLV(syl),
    .MmADDRV(addr), .MmWDV(wd), .MmACKV(ack_a), .MmBUSYV(busy_a), .MmRDV(rd_a),
    .MmRVALV(rval_a), .MmPERRV(perr_a), .MmDERRV(derr_a), .EDmX(ex_a), .EDmY(ey_a)
  );

  core_cycle_seq #(.SYL_W(SW), .ADDR_W(AW), .NCH(1), .RD_CYC(1), .WR_CYC(1)) dut_b (
    .MmCLKV(clk), .MmRSTVN(rst_n), .MmREQV(req_b), .MmWRV(wr), .MmSYLV(syl),
    .MmADDRV(addr), .MmWDV(wd), .MmACKV(ack_b), .MmBUSYV(busy_b), .MmRDV(rd_b),
    .MmRVALV(rval_b), .MmPERRV(perr_b), .MmDERRV(derr_b), .EDmX(ex_b), .EDmY(ey_b)
  );

  function automatic logic [2*SW-1:0] w2(input logic [SW-1:0] s1, input logic [SW-1:0] s0);
    return {s1, s0};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      chk("a_x_eq_y", 64'(ey_a), 64'(ex_a));
      chk("b_x_eq_y", 64'(ey_b), 64'(ex_b));
      chk("b_derr_zero", 64'(derr_b), 64'd0);
      if (rval_a) begin
        if (q_a.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL a_unexpected_rval: got rd=0x%0h, expected no response", rd_a);
        end else begin
          e = q_a.pop_front();
          chk("a_rd", 64'(rd_a), 64'(e.rd));
          chk("a_perr", 64'(perr_a), 64'(e.perr));
          chk("a_derr", 64'(derr_a), 64'(e.derr));
          chk("a_latency", 64'(cyc), 64'(e.cyc));
        end
      end
      if (rval_b) begin
        if (q_b.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL b_unexpected_rval: got rd=0x%0h, expected no response", rd_b);
        end else begin
          e = q_b.pop_front();
          chk("b_rd", 64'(rd_b), 64'(e.rd));
          chk("b_perr", 64'(perr_b), 64'(e.perr));
          chk("b_derr", 64'(derr_b), 64'(e.derr));
          chk("b_latency", 64'(cyc), 64'(e.cyc));
        end
      end
    end
  endtask

  // Raise the request, wait for ACK, queue the expected read response.
  task automatic send(input bit b, input bit w, input logic [1:0] s, input logic [AW-1:0] ad,
                      input logic [2*SW-1:0] d, input logic [2*SW-1:0] erd,
                      input logic [1:0] eperr, input bit ederr, input bit hold,
                      output int unsigned acc);
    bit   got;
    exp_t e;
    got  = 1'b0;
    acc  = 0;
    wr   = w;
    syl  = s;
    addr = ad;
    wd   = d;
    if (b) req_b = 1'b1;
    else   req_a = 1'b1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if ((b ? ack_b : ack_a) == 1'b1) got = 1'b1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s: got no ACK within 40 clocks, expected ACK", b ? "b_ack_wait" : "a_ack_wait");
    end else begin
      acc = cyc;
      chk(b ? "b_busy_on" : "a_busy_on", 64'(b ? busy_b : busy_a), 64'd1);
      chk(b ? "b_drive_on" : "a_drive_on", 64'(b ? ex_b : ex_a), 64'd1);
      if (!w) begin
        e.rd   = erd;
        e.perr = eperr;
        e.derr = ederr;
        e.cyc  = cyc + (b ? 32'd3 : 32'd6);
        if (b) q_b.push_back(e);
        else   q_a.push_back(e);
      end
    end
    if (!hold) begin
      req_a = 1'b0;
      req_b = 1'b0;
    end
  endtask

  task automatic wait_idle(input bit b);
    bit busy;
    busy = b ? busy_b : busy_a;
    for (int i = 0; i < 60 && busy; i++) begin
      @(negedge clk);
      busy = b ? busy_b : busy_a;
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL %s: got BUSY still 1 after 60 clocks, expected 0", b ? "b_idle_wait" : "a_idle_wait");
    end else begin
      chk(b ? "b_drive_off" : "a_drive_off", 64'(b ? ex_b : ex_a), 64'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of run by 100000 time units, expected $finish");
    $fatal(1);
  end

  initial begin
    int unsigned k;
    int unsigned k2;
    int unsigned nack;
    logic [2*SW+1:0] bw;
    rst_n = 1'b0;
    req_a = 1'b0;
    req_b = 1'b0;
    wr    = 1'b0;
    syl   = 2'b00;
    addr  = '0;
    wd    = '0;
    fork
      monitor();
    join_none
    repeat (3) @(negedge clk);
    chk("a_reset_outputs", 64'({ack_a, busy_a, rval_a, perr_a, derr_a, ex_a, ey_a, rd_a}), 64'd0);
    chk("b_reset_outputs", 64'({ack_b, busy_b, rval_b, perr_b, derr_b, ex_b, ey_b, rd_b}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // T1: full write then full read at the top address
    send(0, 1, 2'b11, 12'o7777, w2(14'h0ABC, 14'h1234), '0, 2'b00, 0, 0, k);
    wait_idle(0);
    send(0, 0, 2'b11, 12'o7777, '0, w2(14'h0ABC, 14'h1234), 2'b00, 0, 0, k);
    wait_idle(0);

    // T2: syl1-only write keeps syl0
    send(0, 1, 2'b10, 12'o7777, w2(14'h3FFF, 14'h0000), '0, 2'b00, 0, 0, k);
    wait_idle(0);
    send(0, 0, 2'b11, 12'o7777, '0, w2(14'h3FFF, 14'h1234), 2'b00, 0, 0, k);
    wait_idle(0);

    // Syllable selection on reads: unselected forced to zero, 00 means both
    send(0, 0, 2'b01, 12'o7777, '0, w2(14'h0000, 14'h1234), 2'b00, 0, 0, k);
    wait_idle(0);
    send(0, 0, 2'b10, 12'o7777, '0, w2(14'h3FFF, 14'h0000), 2'b00, 0, 0, k);
    wait_idle(0);
    send(0, 0, 2'b00, 12'o7777, '0, w2(14'h3FFF, 14'h1234), 2'b00, 0, 0, k);
    wait_idle(0);

    // T3: corrupt copy0 syl0 parity, vote picks copy1, then scrubbed
    send(0, 1, 2'b11, 12'o0100, w2(14'h2AAA, 14'h0155), '0, 2'b00, 0, 0, k);
    wait_idle(0);
    bw = dut_a.g_copy[0].mem[12'o0100];
    bw[SW] = ~bw[SW];
    dut_a.g_copy[0].mem[12'o0100] = bw;
    send(0, 0, 2'b11, 12'o0100, '0, w2(14'h2AAA, 14'h0155), 2'b00, 1, 0, k);
    wait_idle(0);
    send(0, 0, 2'b11, 12'o0100, '0, w2(14'h2AAA, 14'h0155), 2'b00, 0, 0, k);
    wait_idle(0);

    // T4: a write request pulsed mid-cycle must be dropped
    send(0, 0, 2'b11, 12'o7777, '0, w2(14'h3FFF, 14'h1234), 2'b00, 0, 0, k);
    nack = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 0) begin
        req_a = 1'b1;
        wr    = 1'b1;
        syl   = 2'b11;
        addr  = 12'o7777;
        wd    = '0;
      end else if (i == 1) begin
        req_a = 1'b0;
      end
      if (ack_a) nack++;
    end
    chk("t4_ignored_ack", 64'(nack), 64'd0);
    wait_idle(0);
    send(0, 0, 2'b11, 12'o7777, '0, w2(14'h3FFF, 14'h1234), 2'b00, 0, 1, k);
    send(0, 0, 2'b11, 12'o7777, '0, w2(14'h3FFF, 14'h1234), 2'b00, 0, 0, k2);
    chk("t4_held_period", 64'(k2 - k), 64'd10);
    wait_idle(0);

    // T5: reset during WRITE of a read loses the word
    send(0, 1, 2'b11, 12'o0005, w2(14'h0222, 14'h0111), '0, 2'b00, 0, 0, k);
    wait_idle(0);
    send(0, 0, 2'b11, 12'o0005, '0, w2(14'h0222, 14'h0111), 2'b00, 0, 0, k);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t5_reset_outputs", 64'({ack_a, busy_a, rval_a, perr_a, derr_a, ex_a, ey_a, rd_a}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(0, 0, 2'b11, 12'o0005, '0, '0, 2'b11, 0, 0, k);
    wait_idle(0);

    // T6: single copy, one-clock phases
    send(1, 1, 2'b11, 12'o0003, w2(14'h0001, 14'h2000), '0, 2'b00, 0, 0, k);
    wait_idle(1);
    send(1, 0, 2'b11, 12'o0003, '0, w2(14'h0001, 14'h2000), 2'b00, 0, 1, k);
    send(1, 0, 2'b11, 12'o0003, '0, w2(14'h0001, 14'h2000), 2'b00, 0, 0, k2);
    chk("t6_held_period", 64'(k2 - k), 64'd4);
    wait_idle(1);
    send(1, 0, 2'b11, 12'o0011, '0, '0, 2'b11, 0, 0, k);
    wait_idle(1);

    repeat (4) @(negedge clk);
    chk("a_responses_drained", 64'(q_a.size()), 64'd0);
    chk("b_responses_drained", 64'(q_b.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
